// File: rtl/battleship_pkg.sv
// Definitions shared by the attacker and defender sides of the battleship exchange.
package battleship_pkg;

  localparam int unsigned DEFAULT_BOARD_N = 5;

  typedef enum logic [1:0] {
    MISS    = 2'd0,
    HIT     = 2'd1,
    REPEAT  = 2'd2,
    INVALID = 2'd3
  } rsp_code_t;

  typedef enum logic [2:0] {
    SETUP,
    ARMED,
    LOOKUP,
    RESPOND,
    DEFEATED
  } defender_state_t;

  // Flat cell index, row-major.
  function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned n = DEFAULT_BOARD_N);
    return row * n + col;
  endfunction

endpackage

// File: rtl/battle_defender.sv
// Defending board: holds ship placement, resolves incoming shots over valid/ready,
// and reports miss/hit/repeat/invalid, remaining life and defeat.
module battle_defender
  import battleship_pkg::*;
#(
  parameter int unsigned BOARD_N = DEFAULT_BOARD_N,
  parameter int unsigned LIFE_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         place_valid,
  input  logic [4:0]                   place_row,
  input  logic [4:0]                   place_col,
  input  logic                         start,
  input  logic                         atk_valid,
  input  logic [4:0]                   atk_row,
  input  logic [4:0]                   atk_col,
  output logic                         atk_ready,
  output logic                         rsp_valid,
  output logic [1:0]                   rsp_code,
  output logic [LIFE_W-1:0]            life,
  output logic                         armed,
  output logic                         lose,
  output logic [BOARD_N*BOARD_N-1:0]   shot_map,
  output logic [BOARD_N*BOARD_N-1:0]   hit_map
);

  localparam int unsigned CELLS = BOARD_N * BOARD_N;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  defender_state_t   state_q;
  logic [CELLS-1:0]  ship_q;
  logic [CELLS-1:0]  shot_q;
  logic [LIFE_W-1:0] life_q;
  logic [4:0]        row_q;
  logic [4:0]        col_q;
  rsp_code_t         code_q;
  rsp_code_t         rsp_code_q;
  logic              rsp_valid_q;

  logic              place_in;
  logic              place_new;
  logic [IDX_W-1:0]  place_idx;
  logic [LIFE_W-1:0] life_place;
  logic              atk_in;
  logic [IDX_W-1:0]  atk_idx;
  rsp_code_t         lookup_code;

  always_comb begin
    place_in   = (32'(place_row) < BOARD_N) && (32'(place_col) < BOARD_N);
    place_idx  = IDX_W'(cell_idx(32'(place_row), 32'(place_col), BOARD_N));
    place_new  = place_valid && place_in && (ship_q[place_idx] == 1'b0);
    life_place = life_q + LIFE_W'(place_new);

    atk_in  = (32'(row_q) < BOARD_N) && (32'(col_q) < BOARD_N);
    atk_idx = IDX_W'(cell_idx(32'(row_q), 32'(col_q), BOARD_N));

    lookup_code = MISS;
    if (!atk_in) begin
      lookup_code = INVALID;
    end else if (shot_q[atk_idx]) begin
      lookup_code = REPEAT;
    end else if (ship_q[atk_idx] && (life_q != '0)) begin
      lookup_code = HIT;
    end
  end

  // RESPOND spans two edges: the first commits the result and raises the pulse,
  // the second drops it and leaves for ARMED or DEFEATED on the updated life.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SETUP;
      ship_q      <= '0;
      shot_q      <= '0;
      life_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      code_q      <= MISS;
      rsp_code_q  <= MISS;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        SETUP: begin
          if (place_new) begin
            ship_q[place_idx] <= 1'b1;
            life_q            <= life_place;
          end
          if (start && (life_place != '0)) state_q <= ARMED;
        end
        ARMED: begin
          if (atk_valid) begin
            row_q   <= atk_row;
            col_q   <= atk_col;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          code_q  <= lookup_code;
          state_q <= RESPOND;
        end
        RESPOND: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= code_q;
            if (code_q == HIT || code_q == MISS) shot_q[atk_idx] <= 1'b1;
            if (code_q == HIT) life_q <= life_q - LIFE_W'(1);
          end else begin
            rsp_valid_q <= 1'b0;
            state_q     <= (life_q == '0) ? DEFEATED : ARMED;
          end
        end
        DEFEATED: ;
        default: state_q <= SETUP;
      endcase
    end
  end

  assign atk_ready = (state_q == ARMED);
  assign armed     = (state_q == ARMED) || (state_q == LOOKUP) || (state_q == RESPOND);
  assign lose      = (state_q == DEFEATED);
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign life      = life_q;
  assign shot_map  = shot_q;
  assign hit_map   = shot_q & ship_q;

endmodule

// File: tb/tb_battle_defender.sv
// Bench for battle_defender: directed tables, hand sequences and a randomized run
// against an array-based model of the board.
module tb_battle_defender;
  import battleship_pkg::*;

  localparam int N     = 5;
  localparam int CELLS = N * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             place_valid, start, atk_valid;
  logic [4:0]       place_row, place_col, atk_row, atk_col;
  logic             atk_ready, rsp_valid, armed, lose;
  logic [1:0]       rsp_code;
  logic [4:0]       life;
  logic [CELLS-1:0] shot_map, hit_map;

  always #5 clk = ~clk;

  battle_defender #(.BOARD_N(N), .LIFE_W(5)) dut (
    .clk(clk), .rst(rst), .place_valid(place_valid), .place_row(place_row),
    .place_col(place_col), .start(start), .atk_valid(atk_valid), .atk_row(atk_row),
    .atk_col(atk_col), .atk_ready(atk_ready), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .life(life), .armed(armed), .lose(lose), .shot_map(shot_map), .hit_map(hit_map)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays of cells plus a life count.
  bit m_ship[CELLS];
  bit m_shot[CELLS];
  int m_life;
  bit m_armed;

  typedef struct {int row; int col; int exp_life;} place_vec_t;
  typedef struct {int row; int col; int exp_code; int exp_life;} atk_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] m_shot_vec();
    logic [CELLS-1:0] v = '0;
    for (int i = 0; i < CELLS; i++) v[i] = m_shot[i];
    return v;
  endfunction

  function automatic logic [CELLS-1:0] m_hit_vec();
    logic [CELLS-1:0] v = '0;
    for (int i = 0; i < CELLS; i++) v[i] = m_shot[i] & m_ship[i];
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; place_valid = 1'b0; start = 1'b0; atk_valid = 1'b0;
    place_row = '0; place_col = '0; atk_row = '0; atk_col = '0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      m_ship[i] = 1'b0;
      m_shot[i] = 1'b0;
    end
    m_life  = 0;
    m_armed = 1'b0;
  endtask

  task automatic place(input int r, input int c, input bit with_start);
    place_valid = 1'b1; place_row = 5'(r); place_col = 5'(c); start = with_start;
    cycle();
    place_valid = 1'b0; start = 1'b0;
    if (!m_armed) begin
      if (r < N && c < N && !m_ship[r*N+c]) begin
        m_ship[r*N+c] = 1'b1;
        m_life++;
      end
      if (with_start && m_life != 0) m_armed = 1'b1;
    end
  endtask

  task automatic attack(input int r, input int c, output int got_code, output int got_life);
    int        waited = 0;
    rsp_code_t exp;
    got_code = -1;
    got_life = -1;
    while (!atk_ready && waited < 20) begin
      cycle();
      waited++;
    end
    if (!atk_ready) begin
      chk("ready_timeout", 64'(atk_ready), 64'(1));
      return;
    end
    atk_valid = 1'b1; atk_row = 5'(r); atk_col = 5'(c);
    cycle();
    atk_valid = 1'b0;
    chk("ready_drop", 64'(atk_ready), 64'(0));
    cycle();
    chk("rsp_early", 64'(rsp_valid), 64'(0));
    if (r >= N || c >= N) exp = INVALID;
    else if (m_shot[r*N+c]) exp = REPEAT;
    else begin
      m_shot[r*N+c] = 1'b1;
      if (m_ship[r*N+c]) begin
        exp = HIT;
        m_life--;
      end else exp = MISS;
    end
    cycle();
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_code", 64'(rsp_code), 64'(exp));
    chk("life", 64'(life), 64'(m_life));
    chk("shot_map", 64'(shot_map), 64'(m_shot_vec()));
    chk("hit_map", 64'(hit_map), 64'(m_hit_vec()));
    got_code = int'(rsp_code);
    got_life = int'(life);
    cycle();
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("rsp_code_hold", 64'(rsp_code), 64'(exp));
    chk("lose_after", 64'(lose), 64'(m_life == 0));
    chk("ready_back", 64'(atk_ready), 64'(m_life != 0));
    chk("armed_after", 64'(armed), 64'(m_life != 0));
  endtask

  place_vec_t place_tbl[4];
  atk_vec_t   atk_tbl[5];

  initial begin
    int gc, gl;

    place_tbl[0] = '{0, 0, 1};
    place_tbl[1] = '{0, 1, 2};
    place_tbl[2] = '{0, 1, 2};
    place_tbl[3] = '{9, 2, 2};
    atk_tbl[0] = '{3, 3, 0, 2};
    atk_tbl[1] = '{0, 0, 1, 1};
    atk_tbl[2] = '{0, 0, 2, 1};
    atk_tbl[3] = '{5, 0, 3, 1};
    atk_tbl[4] = '{0, 1, 1, 0};

    // Reset values
    do_reset();
    chk("rst_ready", 64'(atk_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_code", 64'(rsp_code), 64'(0));
    chk("rst_life", 64'(life), 64'(0));
    chk("rst_armed", 64'(armed), 64'(0));
    chk("rst_lose", 64'(lose), 64'(0));
    chk("rst_maps", 64'({shot_map, hit_map}), 64'(0));

    // Start on an empty board is ignored
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("empty_start_ready", 64'(atk_ready), 64'(0));
    chk("empty_start_armed", 64'(armed), 64'(0));

    foreach (place_tbl[i]) begin
      place(place_tbl[i].row, place_tbl[i].col, 1'b0);
      chk($sformatf("place_life_%0d", i), 64'(life), 64'(place_tbl[i].exp_life));
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    m_armed = 1'b1;
    chk("start_ready", 64'(atk_ready), 64'(1));
    chk("start_armed", 64'(armed), 64'(1));
    chk("start_life", 64'(life), 64'(2));

    foreach (atk_tbl[i]) begin
      attack(atk_tbl[i].row, atk_tbl[i].col, gc, gl);
      chk($sformatf("tbl_code_%0d", i), 64'(gc), 64'(atk_tbl[i].exp_code));
      chk($sformatf("tbl_life_%0d", i), 64'(gl), 64'(atk_tbl[i].exp_life));
    end
    chk("miss_bit18", 64'(shot_map[18]), 64'(1));
    chk("hit_bit0", 64'(hit_map[0]), 64'(1));

    // Once defeated, a held attack is never accepted
    atk_valid = 1'b1; atk_row = 5'd4; atk_col = 5'd4;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("defeat_no_ready", 64'(atk_ready), 64'(0));
      chk("defeat_no_rsp", 64'(rsp_valid), 64'(0));
    end
    atk_valid = 1'b0;
    chk("defeat_lose", 64'(lose), 64'(1));
    chk("defeat_maps", 64'(shot_map), 64'(m_shot_vec()));

    // Placement and start in the same cycle, then reset while in LOOKUP
    do_reset();
    place(1, 1, 1'b1);
    chk("same_cycle_ready", 64'(atk_ready), 64'(1));
    chk("same_cycle_life", 64'(life), 64'(1));
    atk_valid = 1'b1; atk_row = 5'd1; atk_col = 5'd1;
    cycle();
    atk_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_outputs", 64'({atk_ready, rsp_valid, rsp_code, life, armed, lose}), 64'(0));
    chk("midrst_maps", 64'({shot_map, hit_map}), 64'(0));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("midrst_setup", 64'(atk_ready), 64'(0));

    // Randomized rounds against the model
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(1, 10)); k++) begin
        place(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b0);
        chk("rnd_place_life", 64'(life), 64'(m_life));
      end
      start = 1'b1;
      cycle();
      start = 1'b0;
      if (m_life != 0) m_armed = 1'b1;
      chk("rnd_start", 64'(atk_ready), 64'(m_armed));
      if (!m_armed) begin
        place(2, 3, 1'b1);
        chk("rnd_start2", 64'(atk_ready), 64'(1));
      end
      for (int n = 0; n < 60 && m_life > 0; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          place(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);
          chk("rnd_armed_place", 64'(life), 64'(m_life));
        end
        attack(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), gc, gl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
